// File: rtl/tse_phy_mon_pkg.sv
// Package for the PHY speed monitor.
// Contents:
//   - MDIO clause-22 read frame constants.
//   - Bit positions inside the PHY-specific status register.
//   - Speed encoding and the poll FSM state enum.
//   - A helper that builds the 46-bit header a read frame drives.
package tse_phy_mon_pkg;

  // MDIO clause-22 read frame layout
  localparam int         PREAMBLE_LEN   = 32;
  localparam logic [1:0] MDIO_ST        = 2'b01;
  localparam logic [1:0] MDIO_OP_READ   = 2'b10;
  localparam int         FRAME_LEN      = 64;
  localparam int         HDR_LEN        = 46;  // preamble + ST + OP + PHYAD + REGAD
  localparam int         DATA_FIRST_BIT = 48;  // after the two turnaround bits

  // PHY-specific status register fields
  localparam int STAT_SPEED_HI = 15;
  localparam int STAT_SPEED_LO = 14;
  localparam int STAT_DUPLEX   = 13;
  localparam int STAT_RESOLVED = 11;
  localparam int STAT_LINK     = 10;

  // Encoded exactly as the PHY reports bits 15:14; 2'b11 is reserved.
  typedef enum logic [1:0] {
    SPD_10   = 2'b00,
    SPD_100  = 2'b01,
    SPD_1000 = 2'b10
  } speed_e;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_FRAME,
    ST_EVAL
  } mon_state_e;

  function automatic logic [HDR_LEN-1:0] read_header(input logic [4:0] phy_addr,
                                                     input logic [4:0] reg_addr);
    return {{PREAMBLE_LEN{1'b1}}, MDIO_ST, MDIO_OP_READ, phy_addr, reg_addr};
  endfunction

endpackage

// File: rtl/mdio_read_engine.sv
// Runs a single MDIO clause-22 read frame each time start is pulsed while idle.
//
// Ports:
//   clk_clk, reset_reset : system clock and synchronous active-high reset.
//   start                : begin a frame; ignored while a frame is running.
//   phy_addr, reg_addr   : addresses placed in the frame header.
//   mdio_in              : synchronised MDIO pad input.
//   mdc                  : management clock output.
//   mdio_out, mdio_oe    : pad output data and output enable.
//   done                 : one-cycle pulse when the frame completes.
//   rd_data              : the 16 data bits of the last frame, MSB first.
//
// Each bit period is MDC_DIV cycles with mdc low, then MDC_DIV cycles with
// mdc high. Output data changes only where mdc falls, or at frame start.
// Input data is captured on the cycle where mdc rises.
module mdio_read_engine
  import tse_phy_mon_pkg::*;
#(
  parameter int MDC_DIV = 25
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        done,
  output logic [15:0] rd_data
);

  localparam int               DIV_W    = (MDC_DIV < 2) ? 1 : $clog2(MDC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);

  logic               active;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_idx;
  logic [HDR_LEN-1:0] tx_sr;
  logic [HDR_LEN-1:0] header;

  assign header = read_header(phy_addr, reg_addr);

  // NOTE: every register in a clocked block is assigned with <=, so all of
  // them update together from values sampled before the edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      tx_sr    <= '0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_oe  <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active   <= 1'b1;
          div_cnt  <= '0;
          bit_idx  <= '0;
          mdc      <= 1'b0;
          mdio_oe  <= 1'b1;
          mdio_out <= header[HDR_LEN-1];
          tx_sr    <= {header[HDR_LEN-2:0], 1'b0};
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!mdc) begin
          // Rising edge of mdc: the PHY has had a full low half to set up.
          mdc <= 1'b1;
          if (bit_idx >= 6'(DATA_FIRST_BIT)) begin
            rd_data <= {rd_data[14:0], mdio_in};
          end
        end else begin
          mdc <= 1'b0;
          if (bit_idx == 6'(FRAME_LEN - 1)) begin
            active   <= 1'b0;
            done     <= 1'b1;
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx < 6'(HDR_LEN - 1)) begin
              mdio_oe  <= 1'b1;
              mdio_out <= tx_sr[HDR_LEN-1];
              tx_sr    <= {tx_sr[HDR_LEN-2:0], 1'b0};
            end else begin
              // Turnaround and data: release the line to the PHY.
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/tse_phy_speed_monitor.sv
// Polls the PHY-specific status register over MDIO. It drives the TSE MAC
// speed inputs so that the MAC follows the PHY's autonegotiated speed.
//
// Ports:
//   clk_clk, reset_reset : system clock and synchronous active-high reset.
//   mdc, mdio_in, mdio_out, mdio_oe : MDIO management interface.
//   set_10, set_1000     : MAC speed selects; both 0 selects 100 Mb/s.
//   link_up              : last frame was resolved and its speed confirmed.
//   full_duplex          : duplex from the last applied status.
//   speed_change         : one-cycle pulse when set_10/set_1000 change.
//
// A speed is applied only after two consecutive frames report the same
// resolved speed. This filters a single glitchy read.
module tse_phy_speed_monitor
  import tse_phy_mon_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'h10,
  parameter logic [4:0] STATUS_REG  = 5'd17,
  parameter int         MDC_DIV     = 25,
  parameter int         POLL_CYCLES = 500000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  output logic mdc,
  input  logic mdio_in,
  output logic mdio_out,
  output logic mdio_oe,
  output logic set_10,
  output logic set_1000,
  output logic link_up,
  output logic full_duplex,
  output logic speed_change
);

  localparam int POLL_W = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES + 1);

  mon_state_e  state, state_next;
  logic [POLL_W-1:0] poll_cnt;
  logic        start;
  logic        done;
  logic [15:0] rd_data;

  logic        frame_ok;
  speed_e      cand_spd;
  logic        cand_valid;
  speed_e      cand_last;
  logic        apply;

  mdio_read_engine #(
    .MDC_DIV (MDC_DIV)
  ) u_engine (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .start       (start),
    .phy_addr    (PHY_ADDR),
    .reg_addr    (STATUS_REG),
    .mdio_in     (mdio_in),
    .mdc         (mdc),
    .mdio_out    (mdio_out),
    .mdio_oe     (mdio_oe),
    .done        (done),
    .rd_data     (rd_data)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_WAIT;
    else             state <= state_next;
  end

  // NOTE: defaults first, so every path assigns every output and no latch
  // is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      ST_WAIT: begin
        if (poll_cnt == '0) begin
          start      = 1'b1;
          state_next = ST_FRAME;
        end
      end
      ST_FRAME: if (done) state_next = ST_EVAL;
      ST_EVAL:  state_next = ST_WAIT;
      default:  state_next = ST_WAIT;
    endcase
  end

  // The counter resets to 0, so the first frame starts right after reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      poll_cnt <= '0;
    end else if (state == ST_EVAL) begin
      poll_cnt <= POLL_W'(POLL_CYCLES);
    end else if (state == ST_WAIT && poll_cnt != '0) begin
      poll_cnt <= poll_cnt - 1'b1;
    end
  end

  // Status decode. No PHY reads as all ones through the pull-up.
  always_comb begin
    cand_spd = SPD_1000;
    frame_ok = (rd_data != 16'hFFFF) && rd_data[STAT_LINK] && rd_data[STAT_RESOLVED];
    case (rd_data[STAT_SPEED_HI:STAT_SPEED_LO])
      2'b10:   cand_spd = SPD_1000;
      2'b01:   cand_spd = SPD_100;
      2'b00:   cand_spd = SPD_10;
      default: frame_ok = 1'b0;
    endcase
  end

  assign apply = frame_ok && cand_valid && (cand_last == cand_spd);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      set_10       <= 1'b0;
      set_1000     <= 1'b1;
      link_up      <= 1'b0;
      full_duplex  <= 1'b1;
      speed_change <= 1'b0;
      cand_valid   <= 1'b0;
      cand_last    <= SPD_1000;
    end else begin
      speed_change <= 1'b0;
      if (state == ST_EVAL) begin
        if (!frame_ok) begin
          link_up    <= 1'b0;
          cand_valid <= 1'b0;
        end else begin
          cand_valid <= 1'b1;
          cand_last  <= cand_spd;
          if (apply) begin
            set_10       <= (cand_spd == SPD_10);
            set_1000     <= (cand_spd == SPD_1000);
            full_duplex  <= rd_data[STAT_DUPLEX];
            link_up      <= 1'b1;
            speed_change <= (set_10 != (cand_spd == SPD_10)) ||
                            (set_1000 != (cand_spd == SPD_1000));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tse_phy_speed_monitor.sv
module tb_tse_phy_speed_monitor;

  localparam int MDC_DIV   = 2;
  localparam int POLL      = 20;
  localparam int FRAME_CYC = 128 * MDC_DIV;
  localparam int WIN       = FRAME_CYC + 6;

  logic clk_clk     = 1'b0;
  logic reset_reset = 1'b1;
  logic mdio_in     = 1'b1;
  logic mdc, mdio_out, mdio_oe;
  logic set_10, set_1000, link_up, full_duplex, speed_change;

  always #5 clk_clk = ~clk_clk;

  tse_phy_speed_monitor #(
    .PHY_ADDR    (5'h10),
    .STATUS_REG  (5'd17),
    .MDC_DIV     (MDC_DIV),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .mdc          (mdc),
    .mdio_in      (mdio_in),
    .mdio_out     (mdio_out),
    .mdio_oe      (mdio_oe),
    .set_10       (set_10),
    .set_1000     (set_1000),
    .link_up      (link_up),
    .full_duplex  (full_duplex),
    .speed_change (speed_change)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // PHY model: drives bit k of the frame before the k-th mdc rise.
  logic [15:0] phy_data = 16'hFFFF;
  int   rise_cnt = 0;
  logic prev_mdc = 1'b0;
  logic prev_oe  = 1'b0;

  always @(negedge clk_clk) begin
    if (reset_reset) begin
      rise_cnt = 0;
    end else begin
      if (mdio_oe && !prev_oe) rise_cnt = 0;
      if (mdc && !prev_mdc) rise_cnt++;
    end
    prev_mdc = mdc;
    prev_oe  = mdio_oe;
    mdio_in  = (rise_cnt >= 48 && rise_cnt < 64) ? phy_data[63 - rise_cnt] : 1'b1;
  end

  // 01 10 10000 10001 after 32 preamble ones
  logic [45:0] exp_hdr;
  initial exp_hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b10000, 5'b10001};

  task automatic wait_frame_start();
    logic p;
    bit   found;
    p     = mdio_oe;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_clk);
      if (mdio_oe && !p) found = 1;
      p = mdio_oe;
    end
    if (!found) check("frame_start_timeout", mdio_oe, 1'b1);
  endtask

  // Observes one frame from its start; records driven bits at each mdc rise.
  task automatic capture_frame(output logic [63:0] bits, output int rises,
                               output int oe_off_bit, output int sc_cnt);
    logic p;
    p          = mdc;
    bits       = '0;
    rises      = 0;
    oe_off_bit = -1;
    sc_cnt     = 0;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk_clk);
      if (speed_change) sc_cnt++;
      if (mdc && !p) begin
        if (rises < 64) bits[63 - rises] = mdio_out;
        if (!mdio_oe && oe_off_bit < 0) oe_off_bit = rises;
        rises++;
      end
      p = mdc;
    end
  endtask

  task automatic run_frame(input logic [15:0] data, output int sc_cnt);
    logic [63:0] bits;
    int rises, oe_off;
    wait_frame_start();
    phy_data = data;
    capture_frame(bits, rises, oe_off, sc_cnt);
  endtask

  task automatic check_outs(input string tag, input logic e10, input logic e1000,
                            input logic elink, input logic efd);
    check({tag, ".set_10"},      set_10,      e10);
    check({tag, ".set_1000"},    set_1000,    e1000);
    check({tag, ".link_up"},     link_up,     elink);
    check({tag, ".full_duplex"}, full_duplex, efd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] bits;
    int rises, oe_off, sc;
    int p;

    // Reset values
    repeat (4) @(posedge clk_clk);
    #1;
    check("rst.mdc", mdc, 1'b0);
    check("rst.mdio_oe", mdio_oe, 1'b0);
    check("rst.mdio_out", mdio_out, 1'b1);
    check("rst.speed_change", speed_change, 1'b0);
    check_outs("rst", 1'b0, 1'b1, 1'b0, 1'b1);

    // First frame starts the cycle after release
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
    check("first.start_oe", mdio_oe, 1'b1);
    check("first.start_mdc", mdc, 1'b0);
    capture_frame(bits, rises, oe_off, sc);
    check("first.rises", rises, 64);
    check("first.preamble", bits[63:32], 32'hFFFF_FFFF);
    check("first.header", bits[63:18], exp_hdr);
    check("first.oe_off_bit", oe_off, 46);
    check_outs("first.nophy", 1'b0, 1'b1, 1'b0, 1'b1);

    // Gigabit bring-up
    run_frame(16'hAC00, sc);
    check_outs("gig1", 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(16'hAC00, sc);
    check_outs("gig2", 1'b0, 1'b1, 1'b1, 1'b1);
    check("gig2.speed_change", sc, 0);

    // Downshift to 100
    run_frame(16'h6C00, sc);
    check_outs("d100_1", 1'b0, 1'b1, 1'b1, 1'b1);
    check("d100_1.speed_change", sc, 0);
    run_frame(16'h6C00, sc);
    check_outs("d100_2", 1'b0, 1'b0, 1'b1, 1'b1);
    check("d100_2.speed_change", sc, 1);

    // 10 Mb/s half duplex
    run_frame(16'h0C00, sc);
    run_frame(16'h0C00, sc);
    check_outs("d10", 1'b1, 1'b0, 1'b1, 1'b0);
    check("d10.speed_change", sc, 1);

    // Back to 100 full duplex
    run_frame(16'h6C00, sc);
    run_frame(16'h6C00, sc);
    check_outs("back100", 1'b0, 1'b0, 1'b1, 1'b1);

    // No PHY, unresolved, single resolved, then confirmed
    run_frame(16'hFFFF, sc);
    check_outs("nophy", 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(16'h6400, sc);
    check_outs("unres", 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(16'h6C00, sc);
    check_outs("single", 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(16'h6C00, sc);
    check_outs("restore", 1'b0, 1'b0, 1'b1, 1'b1);
    check("restore.speed_change", sc, 0);

    // Reset during data bit 50 of a frame (candidate 100 is stored)
    wait_frame_start();
    phy_data = 16'h6C00;
    p = 0;
    for (int i = 0; i < 2 * FRAME_CYC && p < 51; i++) begin
      @(negedge clk_clk);
      if (mdc && !prev_mdc_q()) p++;
    end
    check("midrst.reached_bit50", p, 51);
    reset_reset = 1'b1;
    @(posedge clk_clk);
    #1;
    check("midrst.mdc", mdc, 1'b0);
    check("midrst.mdio_oe", mdio_oe, 1'b0);
    check_outs("midrst", 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
    check("midrst.restart_oe", mdio_oe, 1'b1);
    capture_frame(bits, rises, oe_off, sc);
    check("midrst.rises", rises, 64);
    check("midrst.header", bits[63:18], exp_hdr);
    // Stored candidate was cleared, so one 100 frame must not apply.
    check_outs("midrst.after", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // mdc as it was one clock earlier, for rise detection in the main sequence
  logic mdc_d = 1'b0;
  always @(posedge clk_clk) mdc_d <= mdc;
  function automatic logic prev_mdc_q();
    return mdc_d;
  endfunction

endmodule

// File: doc/tse_phy_speed_monitor.md
# tse_phy_speed_monitor

Polls the external Ethernet PHY's specific-status register over MDIO. It decodes the resolved link speed and drives the TSE MAC status inputs `set_10`/`set_1000` of `nios_system` directly. It is the stage immediately upstream of the MAC status connection, so the MAC follows the PHY's autonegotiated speed without software involvement.

## Interface
- `PHY_ADDR`, 5'h10: MDIO PHY address.
- `STATUS_REG`, 5'd17: PHY-specific status register.
  - bit 15:14 speed
  - bit 13 duplex
  - bit 11 resolved
  - bit 10 link
- `MDC_DIV`, 25: `clk_clk` cycles per MDC half-period; legal range ≥2.
- `POLL_CYCLES`, 500000: idle `clk_clk` cycles between the end of one frame and the start of the next.
- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `mdc`  out  1  MDIO management clock.
- `mdio_in`  in  1  MDIO pad input, already synchronised; board pull-up.
- `mdio_out`  out  1  MDIO pad output data.
- `mdio_oe`  out  1  MDIO pad output enable; 1 = drive.
- `set_10`  out  1  to `tse_mac_mac_status_connection_set_10`.
- `set_1000`  out  1  to `tse_mac_mac_status_connection_set_1000`.
- `link_up`  out  1  PHY reports link up and speed resolved.
- `full_duplex`  out  1  last accepted duplex.
- `speed_change`  out  1  one-cycle pulse on any change of `set_10`/`set_1000`.

## Operation
- Reset values:
  - `mdc` 0, `mdio_oe` 0, `mdio_out` 1.
  - `set_10` 0, `set_1000` 1 (gigabit default).
  - `link_up` 0, `full_duplex` 1, `speed_change` 0.
- FSM states: WAIT, FRAME, EVAL.
  - WAIT: the poll counter counts down; at 0 → FRAME.
  - After reset, WAIT is entered with counter 0, so the first frame starts on the first cycle after reset deasserts.
  - FRAME: 64 bit periods, then → EVAL.
  - EVAL: one cycle, then → WAIT with counter = `POLL_CYCLES`.
- Frame bits, MSB first:
  - 0–31: preamble, all 1.
  - 32–33: ST = 01.
  - 34–35: OP = 10 (read).
  - 36–40: `PHY_ADDR`.
  - 41–45: `STATUS_REG`.
  - 46–47: turnaround; `mdio_oe` = 0.
  - 48–63: data, sampled into the 16-bit `rd_data`.
- Decode in EVAL:
  - `rd_data` == 16'hFFFF (no PHY): `link_up` ← 0; speed outputs held.
  - bit 10 = 0 or bit 11 = 0: `link_up` ← 0; speed outputs held.
  - Otherwise the candidate speed is bits 15:14:
    - 10 → 1000 (`set_1000`=1, `set_10`=0).
    - 01 → 100 (both 0).
    - 00 → 10 (`set_10`=1, `set_1000`=0).
    - 11 → reserved; treated as not resolved.
- Confirmation:
  - A candidate is applied only if it equals the candidate from the immediately preceding frame.
  - Applying a candidate updates `set_10`, `set_1000`, `full_duplex` (bit 13) and sets `link_up` ← 1.
  - Any unresolved or no-PHY frame clears the stored candidate.
- `set_10` and `set_1000` are never 1 simultaneously.
- `speed_change` pulses in the EVAL cycle when the applied speed differs from the prior one.

## Timing
- Bit period = 2·`MDC_DIV` clk cycles.
- Each bit starts with `mdc` low for `MDC_DIV` cycles, then high for `MDC_DIV` cycles.
- `mdio_out`/`mdio_oe` change only on the cycle `mdc` falls (or at frame start), giving a setup of `MDC_DIV` cycles.
- Data bits are sampled on the clk cycle where `mdc` rises (end of the low half).
- Frame length is 128·`MDC_DIV` cycles; at `MDC_DIV`=25 this is 3200 cycles, ~64 µs at 50 MHz.
- Outputs update registered, on the cycle after EVAL; there is no combinational path from `mdio_in`.
- Between frames: `mdc` = 0, `mdio_oe` = 0.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values, the frame is abandoned and the stored candidate is cleared.
- The poll counter is wide enough for `POLL_CYCLES` with no wrap; `POLL_CYCLES`=0 gives back-to-back frames separated by one WAIT cycle.

## Structure
- Package `tse_phy_mon_pkg` holds:
  - MDIO constants: preamble length 32, ST 2'b01, OP_READ 2'b10, frame length 64.
  - Status bit positions 15/14/13/11/10.
  - Speed encoding typedef: SPD_10, SPD_100, SPD_1000.
  - FSM state enum.
- Sub-module `mdio_read_engine`:
  - Handles MDC generation, the frame shift register and turnaround.
  - Inputs: start pulse, phy/reg address.
  - Outputs: `done` pulse and `rd_data[15:0]`.
- The top level keeps the poll timer, decode, confirmation and output registers.

## Test plan
- **Reset and first frame**: with `MDC_DIV`=2, after reset check that:
  - the frame starts on the cycle after release;
  - the first 32 bits are 1, then 01 10 10000 10001;
  - `mdio_oe` drops at bit 46;
  - there are exactly 64 `mdc` rising edges.
- **Gigabit bring-up**: PHY model returns 16'hAC00 on two consecutive frames.
  - After frame 1: no change (`set_1000`=1 from reset, `link_up`=0).
  - After frame 2: `link_up`=1, `full_duplex`=1, `speed_change`=0.
- **Downshift to 100**: after gigabit is established, the model returns 16'h6C00 twice.
  - After the second frame: `set_1000`=0, `set_10`=0, and `speed_change` is a single pulse.
- **10 Mb/s half duplex**: model returns 16'h0C00 twice.
  - `set_10`=1, `set_1000`=0, `full_duplex`=0.
- **No PHY / unresolved**: with outputs at 100, the model returns 16'hFFFF, then 16'h6400 (unresolved), then 16'h6C00.
  - After each of these three frames: `link_up`=0 and speed held.
  - A following 16'h6C00 restores `link_up`=1 at 100.
- **Reset mid-frame**: assert `reset_reset` at frame bit 50 for one cycle.
  - Next cycle: `mdc`=0, `mdio_oe`=0, `set_1000`=1.
  - A fresh full frame follows.
